// File: rtl/sm_regdump.sv
// Register-file dumper: walks regAddr over every CPU register and streams each word as bytes.
// Define SM_REGDUMP_HEX_EN for 8 ASCII hex chars + newline per register; otherwise 4 raw bytes, MSB first.
module sm_regdump #(
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] regAddr,
    input  logic [DATA_W-1:0] regData,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);
`ifdef SM_REGDUMP_HEX_EN
    localparam int BYTES = 9;
`else
    localparam int BYTES = 4;
`endif
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(REG_COUNT - 1);
    localparam logic [3:0]        LAST_BYTE = 4'(BYTES - 1);

    // Handshake: a byte moves on a clk edge where tx_valid & tx_ready; while tx_valid is high
    // and tx_ready is low, tx_data and tx_valid hold; only rst may drop tx_valid early.
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shift_q;
    logic [3:0]          cnt_q;
    logic [7:0]          cur_byte;
    logic                xfer, last_byte, last_reg;

    assign xfer      = (state == S_SEND) && tx_ready;
    assign last_byte = (cnt_q == LAST_BYTE);
    assign last_reg  = (regAddr == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            regAddr <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE:  if (start) regAddr <= '0;
                S_FETCH: begin
                    shift_q <= regData;
                    cnt_q   <= '0;
                end
                S_SEND: if (xfer) begin
                    if (!last_byte) cnt_q <= cnt_q + 4'd1;
                    else if (!last_reg) regAddr <= regAddr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_SEND;
            S_SEND:  if (xfer && last_byte) state_nxt = last_reg ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef SM_REGDUMP_HEX_EN
    logic [3:0] nib;
    always_comb begin
        nib = 4'h0;
        case (cnt_q)
            4'd0: nib = shift_q[31:28];
            4'd1: nib = shift_q[27:24];
            4'd2: nib = shift_q[23:20];
            4'd3: nib = shift_q[19:16];
            4'd4: nib = shift_q[15:12];
            4'd5: nib = shift_q[11:8];
            4'd6: nib = shift_q[7:4];
            4'd7: nib = shift_q[3:0];
            default: nib = 4'h0;
        endcase
        // 0x37 + 10 = 'A'
        if (last_byte)         cur_byte = 8'h0A;
        else if (nib < 4'd10)  cur_byte = 8'h30 + {4'h0, nib};
        else                   cur_byte = 8'h37 + {4'h0, nib};
    end
`else
    always_comb begin
        cur_byte = 8'h00;
        case (cnt_q)
            4'd0: cur_byte = shift_q[31:24];
            4'd1: cur_byte = shift_q[23:16];
            4'd2: cur_byte = shift_q[15:8];
            4'd3: cur_byte = shift_q[7:0];
            default: cur_byte = 8'h00;
        endcase
    end
`endif

    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        tx_valid = (state == S_SEND);
        tx_data  = tx_valid ? cur_byte : 8'h00;
    end

endmodule

// File: tb/tb_sm_regdump.sv
// Bench for sm_regdump: model builds the expected byte stream from the register file contents;
// a monitor checks every transfer, handshake hold and regAddr sweep; directed tests pin literals.
module tb_sm_regdump;
  localparam int REG_COUNT = 32;
`ifdef SM_REGDUMP_HEX_EN
  localparam int B = 9;
`else
  localparam int B = 4;
`endif

  logic        clk = 1'b0;
  logic        rst, start, busy, done, tx_valid, tx_ready;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic [7:0]  tx_data;
  logic [31:0] rf [REG_COUNT];

  sm_regdump #(.REG_COUNT(REG_COUNT), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .regAddr(regAddr), .regData(regData),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  assign regData = rf[regAddr];
  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          byte_cnt = 0, done_cnt = 0, hold_cnt = 0;
  bit          mon_en = 0, ready_toggle = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic [4:0]  prev_addr = 5'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected stream straight from the register contents.
  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r < REG_COUNT; r++) begin
`ifdef SM_REGDUMP_HEX_EN
      for (int i = 0; i < 8; i++) begin
        int nv;
        nv = int'((rf[r] >> (28 - 4 * i)) & 32'hF);
        exp_q.push_back(nv < 10 ? 8'(48 + nv) : 8'(65 + nv - 10));
      end
      exp_q.push_back(8'h0A);
`else
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((rf[r] >> (24 - 8 * i)) & 32'hFF));
`endif
    end
  endtask

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = ready_toggle ? ~tx_ready : 1'b1;
    end
  end

  // Monitor: every transfer against the model, handshake hold, regAddr sweep, done placement.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, prev_data);
      end
      if (regAddr != prev_addr) begin
        if (regAddr != 5'd0) begin
          chk("addr_step", regAddr, prev_addr + 1);
          chk("addr_hold", hold_cnt >= 2, 1);
        end
        hold_cnt = 1;
      end else hold_cnt++;
      prev_addr = regAddr;
      if (tx_valid && tx_ready && !rst) begin
        if (exp_q.size() == 0) chk("extra_byte", 1, 0);
        else chk("byte", tx_data, exp_q.pop_front());
        got_q.push_back(tx_data);
        byte_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last", exp_q.size(), 0);
      end
      prev_stall = tx_valid && !tx_ready && !rst;
      prev_data  = tx_data;
    end
  end

  // One dump; cycles = edges after the start edge at which done is first seen high.
  task automatic run_dump(input bit toggle, input int restart_at, input int reset_at,
                          output bit aborted, output int cycles);
    int n, d0;
    bit restarted, do_rst;
    restarted = 0; do_rst = 0; aborted = 0;
    build_expected();
    got_q.delete();
    byte_cnt = 0; d0 = done_cnt;
    ready_toggle = toggle;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (n == 0) begin
        chk("busy_after_start", busy, 1);
        chk("fetch_no_valid", tx_valid, 0);
      end
      if (n == 1) chk("first_valid", tx_valid, 1);
      if (do_rst) begin
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_regaddr", regAddr, 0);
        aborted = 1;
        break;
      end
      if (done) break;
      if (n >= 4000) begin
        chk("done_timeout", 0, 1);
        break;
      end
      @(posedge clk); n++; #1;
      start = (restart_at >= 0 && !restarted && byte_cnt >= restart_at);
      if (start) restarted = 1;
      if (reset_at >= 0 && byte_cnt >= reset_at) begin
        rst = 1'b1;
        do_rst = 1;
      end
    end
    cycles = n;
    if (aborted) begin
      repeat (3) @(negedge clk);
      chk("no_done_after_rst", done_cnt - d0, 0);
      chk("idle_after_rst", busy, 0);
    end else begin
      chk("byte_total", byte_cnt, REG_COUNT * B);
      chk("exp_drained", exp_q.size(), 0);
      chk("last_addr", regAddr, REG_COUNT - 1);
      if (!toggle) chk("done_latency", n, (1 + B) * REG_COUNT);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      chk("done_count", done_cnt - d0, 1);
    end
  endtask

  bit         ab;
  int         cyc;
  logic [7:0] lit [9];

  initial begin
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) rf[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_regaddr", regAddr, 0);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1;

    // Sparse file, tx_ready held high: pinned latency and byte positions.
    rf[1]  = 32'h12345678;
    rf[10] = 32'h00ABCDEF;
    run_dump(0, -1, -1, ab, cyc);
`ifdef SM_REGDUMP_HEX_EN
    chk("latency_literal", cyc, 320);
    lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0A};
    for (int i = 0; i < 9; i++) chk("reg1_hex_char", got_q[9 + i], lit[i]);
    lit = '{8'h30, 8'h30, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0A};
    for (int i = 0; i < 9; i++) chk("reg10_hex_char", got_q[90 + i], lit[i]);
    chk("reg0_first_char", got_q[0], 8'h30);
`else
    chk("latency_literal", cyc, 160);
    lit = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'hAB, 8'hCD, 8'hEF, 8'h00};
    for (int i = 0; i < 4; i++) chk("reg1_raw_byte", got_q[4 + i], lit[i]);
    for (int i = 0; i < 4; i++) chk("reg10_raw_byte", got_q[40 + i], lit[4 + i]);
    chk("reg0_first_byte", got_q[0], 8'h00);
`endif

    // Dense file under backpressure (tx_ready toggling every cycle).
    for (int i = 0; i < REG_COUNT; i++) rf[i] = (32'(i) * 32'h01030507) ^ 32'hA5C30F96;
    run_dump(1, -1, -1, ab, cyc);

    // start pulsed mid-dump must be ignored.
    run_dump(0, 50, -1, ab, cyc);

    // Reset mid-dump, then start and rst together, then a clean full dump.
    run_dump(0, -1, 10, ab, cyc);
    chk("dump_aborted", ab, 1);
    @(posedge clk); #1; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1; start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_beats_start_busy", busy, 0);
    chk("rst_beats_start_valid", tx_valid, 0);
    run_dump(0, -1, -1, ab, cyc);
    chk("redump_from_reg0", got_q[0], exp_first_byte());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // First byte of the stream for the current rf[0].
  function automatic logic [7:0] exp_first_byte();
`ifdef SM_REGDUMP_HEX_EN
    int nv;
    nv = int'(rf[0] >> 28);
    return nv < 10 ? 8'(48 + nv) : 8'(65 + nv - 10);
`else
    return rf[0][31:24];
`endif
  endfunction

endmodule
